// File: rtl/dmac_apb_cfg_if.sv
// APB3 bus bundle for the DMA configuration block; signal names follow the
// slave's view of the bus.
interface dmac_apb_cfg_if;
   logic        psel_i;
   logic        penable_i;
   logic [11:0] paddr_i;
   logic        pwrite_i;
   logic [31:0] pwdata_i;
   logic        pready_o;
   logic [31:0] prdata_o;
   logic        pslverr_o;

   modport slave (
      input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      output pready_o, prdata_o, pslverr_o
   );

   modport master (
      output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
      input  pready_o, prdata_o, pslverr_o
   );
endinterface

// File: rtl/dmac_apb_cfg.sv
// APB3 register block in front of the DMA engine: address/length registers,
// start pulse generation, completion counting and a sticky maskable interrupt.
module dmac_apb_cfg #(
   parameter logic [31:0] VERSION = 32'h0001_2024
) (
   input  logic               clk,
   input  logic               rst,
   dmac_apb_cfg_if.slave      apb,
   output logic [31:0]        src_addr_o,
   output logic [31:0]        dst_addr_o,
   output logic [15:0]        byte_len_o,
   output logic               start_o,
   input  logic               done_i,
   output logic               irq_o
);

   // Word addresses (byte address >> 2)
   localparam logic [9:0] A_VERSION  = 10'h000;
   localparam logic [9:0] A_SRC      = 10'h040;
   localparam logic [9:0] A_DST      = 10'h041;
   localparam logic [9:0] A_LEN      = 10'h042;
   localparam logic [9:0] A_CMD      = 10'h043;
   localparam logic [9:0] A_STATUS   = 10'h044;
   localparam logic [9:0] A_IRQ_EN   = 10'h045;
   localparam logic [9:0] A_IRQ_CLR  = 10'h046;
   localparam logic [9:0] A_XFER_CNT = 10'h047;

   logic        irq_en;
   logic        irq_pend;
   logic        done_d;
   logic [31:0] xfer_cnt;

   logic [9:0]  waddr;
   logic        setup;
   logic        access;
   logic        mapped;
   logic        read_only;
   logic [31:0] rd_data;
   logic        err;
   logic        wr_ok;
   logic        rise;
   logic        irq_pend_nxt;
   logic        irq_en_nxt;

   assign waddr  = apb.paddr_i[11:2];
   assign setup  = apb.psel_i & ~apb.penable_i;
   assign access = apb.psel_i &  apb.penable_i;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      rd_data   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      case (waddr)
         A_VERSION:  begin rd_data = VERSION; read_only = 1'b1; end
         A_SRC:      rd_data = src_addr_o;
         A_DST:      rd_data = dst_addr_o;
         A_LEN:      rd_data = {16'h0, byte_len_o};
         A_CMD:      rd_data = '0;
         A_STATUS:   begin rd_data = {30'h0, irq_pend, done_i}; read_only = 1'b1; end
         A_IRQ_EN:   rd_data = {31'h0, irq_en};
         A_IRQ_CLR:  rd_data = '0;
         A_XFER_CNT: begin rd_data = xfer_cnt; read_only = 1'b1; end
         default:    mapped = 1'b0;
      endcase
   end

   // A start request while the engine is busy is rejected, not queued.
   assign err = ~mapped
              | (apb.pwrite_i & read_only)
              | (apb.pwrite_i & (waddr == A_CMD) & apb.pwdata_i[0] & ~done_i);

   assign apb.pslverr_o = access & err & ~rst;
   assign apb.pready_o  = 1'b1;
   assign wr_ok         = access & apb.pwrite_i & ~err;
   assign rise          = done_i & ~done_d;

   // Next-state values feed the registered irq_o so it tracks irq_pend/irq_en with no extra lag.
   always_comb begin
      irq_pend_nxt = irq_pend;
      irq_en_nxt   = irq_en;
      if (wr_ok && waddr == A_IRQ_EN)
         irq_en_nxt = apb.pwdata_i[0];
      if (rise)
         irq_pend_nxt = 1'b1;
      else if (wr_ok && waddr == A_IRQ_CLR && apb.pwdata_i[0])
         irq_pend_nxt = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_addr_o   <= '0;
         dst_addr_o   <= '0;
         byte_len_o   <= '0;
         start_o      <= 1'b0;
         irq_en       <= 1'b0;
         irq_pend     <= 1'b0;
         irq_o        <= 1'b0;
         done_d       <= 1'b1;
         xfer_cnt     <= '0;
         apb.prdata_o <= '0;
      end else begin
         if (wr_ok && waddr == A_SRC) src_addr_o <= apb.pwdata_i;
         if (wr_ok && waddr == A_DST) dst_addr_o <= apb.pwdata_i;
         if (wr_ok && waddr == A_LEN) byte_len_o <= apb.pwdata_i[15:0];
         start_o      <= wr_ok & (waddr == A_CMD) & apb.pwdata_i[0];
         irq_en       <= irq_en_nxt;
         irq_pend     <= irq_pend_nxt;
         irq_o        <= irq_pend_nxt & irq_en_nxt;
         done_d       <= done_i;
         if (rise) xfer_cnt <= xfer_cnt + 32'd1;
         apb.prdata_o <= (setup && !apb.pwrite_i) ? rd_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_dmac_apb_cfg.sv
// Directed bench for dmac_apb_cfg: a vector table of APB accesses plus
// hand-written sequences for start, completion, interrupt, wrap and reset.
module tb_dmac_apb_cfg;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] byte_len;
   logic        start, done, irq;

   dmac_apb_cfg_if apb ();

   dmac_apb_cfg dut (
      .clk        (clk),
      .rst        (rst),
      .apb        (apb.slave),
      .src_addr_o (src_addr),
      .dst_addr_o (dst_addr),
      .byte_len_o (byte_len),
      .start_o    (start),
      .done_i     (done),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int start_cnt = 0;
   logic irq_seen = 1'b0;

   always @(negedge clk) begin
      if (start === 1'b1) start_cnt <= start_cnt + 1;
      if (irq === 1'b1)   irq_seen  <= 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
      @(posedge clk); #1;
      apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
      apb.paddr_i = addr; apb.pwdata_i = data;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      @(negedge clk);
      err = apb.pslverr_o;
      @(posedge clk); #1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] addr, output logic [31:0] data, output logic err);
      @(posedge clk); #1;
      apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
      apb.paddr_i = addr; apb.pwdata_i = '0;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      @(negedge clk);
      data = apb.prdata_o;
      err  = apb.pslverr_o;
      @(posedge clk); #1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
   endtask

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic        err;
      logic [31:0] rd;

      vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0001_2024, 1'b0};
      vecs[1]  = '{1'b0, 12'h108, 32'h0,         32'h0,         1'b0};
      vecs[2]  = '{1'b0, 12'h110, 32'h0,         32'h1,         1'b0};
      vecs[3]  = '{1'b0, 12'h11C, 32'h0,         32'h0,         1'b0};
      vecs[4]  = '{1'b1, 12'h100, 32'h1000,      32'h0,         1'b0};
      vecs[5]  = '{1'b1, 12'h104, 32'h2000,      32'h0,         1'b0};
      vecs[6]  = '{1'b1, 12'h108, 32'hFFFF_0040, 32'h0,         1'b0};
      vecs[7]  = '{1'b0, 12'h100, 32'h0,         32'h1000,      1'b0};
      vecs[8]  = '{1'b0, 12'h104, 32'h0,         32'h2000,      1'b0};
      vecs[9]  = '{1'b0, 12'h108, 32'h0,         32'h40,        1'b0};
      vecs[10] = '{1'b1, 12'h000, 32'hDEAD_BEEF, 32'h0,         1'b1};
      vecs[11] = '{1'b0, 12'h000, 32'h0,         32'h0001_2024, 1'b0};
      vecs[12] = '{1'b0, 12'h0F0, 32'h0,         32'h0,         1'b1};
      vecs[13] = '{1'b1, 12'h110, 32'h1,         32'h0,         1'b1};
      vecs[14] = '{1'b1, 12'h11C, 32'h5,         32'h0,         1'b1};
      vecs[15] = '{1'b1, 12'h10C, 32'h0,         32'h0,         1'b0};
      vecs[16] = '{1'b0, 12'h10C, 32'h0,         32'h0,         1'b0};
      vecs[17] = '{1'b1, 12'h114, 32'h3,         32'h0,         1'b0};
      vecs[18] = '{1'b0, 12'h114, 32'h0,         32'h1,         1'b0};
      vecs[19] = '{1'b1, 12'h114, 32'h0,         32'h0,         1'b0};
      vecs[20] = '{1'b0, 12'h118, 32'h0,         32'h0,         1'b0};
      vecs[21] = '{1'b0, 12'h110, 32'h0,         32'h1,         1'b0};
      vecs[22] = '{1'b1, 12'h0F0, 32'h1,         32'h0,         1'b1};

      apb.psel_i = 1'b0; apb.penable_i = 1'b0; apb.pwrite_i = 1'b0;
      apb.paddr_i = '0; apb.pwdata_i = '0;
      done = 1'b1;
      rst  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset start_o",   {31'h0, start},         32'h0);
      check("reset irq_o",     {31'h0, irq},           32'h0);
      check("reset src",       src_addr,               32'h0);
      check("reset len",       {16'h0, byte_len},      32'h0);
      check("reset prdata",    apb.prdata_o,           32'h0);
      check("reset pready",    {31'h0, apb.pready_o},  32'h1);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) begin
            apb_write(vecs[i].addr, vecs[i].wdata, err);
            check($sformatf("vec%0d wr err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         end else begin
            apb_read(vecs[i].addr, rd, err);
            check($sformatf("vec%0d rd data", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d rd err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         end
      end
      check("table src_addr_o", src_addr, 32'h1000);
      check("table dst_addr_o", dst_addr, 32'h2000);
      check("table byte_len_o", {16'h0, byte_len}, 32'h40);
      check("table no start",   start_cnt, 0);
      check("table irq quiet",  {31'h0, irq_seen}, 32'h0);

      // Valid start: one-cycle pulse, engine goes busy the cycle after
      apb_write(12'h10C, 32'h1, err);
      check("start err", {31'h0, err}, 32'h0);
      check("start high T+1", {31'h0, start}, 32'h1);
      @(posedge clk); #1;
      done = 1'b0;
      check("start low T+2", {31'h0, start}, 32'h0);
      check("start count 1", start_cnt, 1);

      // Start while busy is rejected; address writes still land
      apb_write(12'h10C, 32'h1, err);
      check("busy cmd err", {31'h0, err}, 32'h1);
      repeat (2) @(posedge clk);
      #1;
      check("busy no start", start_cnt, 1);
      apb_write(12'h100, 32'h3000, err);
      check("busy src err", {31'h0, err}, 32'h0);
      check("busy src out", src_addr, 32'h3000);

      // Completion with interrupt enabled
      apb_write(12'h114, 32'h1, err);
      @(posedge clk); #1;
      done = 1'b1;
      @(negedge clk);
      check("irq before edge", {31'h0, irq}, 32'h0);
      @(posedge clk); #1;
      check("irq after rise", {31'h0, irq}, 32'h1);
      apb_read(12'h11C, rd, err);
      check("xfer_cnt 1", rd, 32'h1);
      apb_read(12'h110, rd, err);
      check("status pend", rd, 32'h3);
      apb_write(12'h118, 32'h1, err);
      check("irq cleared", {31'h0, irq}, 32'h0);
      apb_read(12'h110, rd, err);
      check("status cleared", rd, 32'h1);

      // Clear and done rise in the same cycle: set wins
      apb_write(12'h10C, 32'h1, err);
      @(posedge clk); #1;
      done = 1'b0;
      @(posedge clk); #1;
      apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
      apb.paddr_i = 12'h118; apb.pwdata_i = 32'h1;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      done = 1'b1;
      @(posedge clk); #1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
      check("set wins irq", {31'h0, irq}, 32'h1);
      apb_write(12'h114, 32'h0, err);
      check("masked irq", {31'h0, irq}, 32'h0);
      apb_read(12'h110, rd, err);
      check("masked status", rd, 32'h3);
      apb_read(12'h11C, rd, err);
      check("xfer_cnt 2", rd, 32'h2);
      apb_write(12'h114, 32'h1, err);
      check("unmask irq", {31'h0, irq}, 32'h1);
      check("start count 2", start_cnt, 2);

      // Counter wrap via backdoor preload
      force dut.xfer_cnt = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      release dut.xfer_cnt;
      apb_read(12'h11C, rd, err);
      check("xfer_cnt preload", rd, 32'hFFFF_FFFF);
      apb_write(12'h10C, 32'h1, err);
      @(posedge clk); #1;
      done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      done = 1'b1;
      repeat (2) @(posedge clk);
      apb_read(12'h11C, rd, err);
      check("xfer_cnt wrap", rd, 32'h0);
      check("start count 3", start_cnt, 3);

      // Reset in the access phase of a valid start write
      @(posedge clk); #1;
      apb.psel_i = 1'b1; apb.penable_i = 1'b0; apb.pwrite_i = 1'b1;
      apb.paddr_i = 12'h10C; apb.pwdata_i = 32'h1;
      @(posedge clk); #1;
      apb.penable_i = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      apb.psel_i = 1'b0; apb.penable_i = 1'b0;
      check("rst start_o", {31'h0, start}, 32'h0);
      check("rst src",     src_addr, 32'h0);
      check("rst dst",     dst_addr, 32'h0);
      check("rst len",     {16'h0, byte_len}, 32'h0);
      check("rst irq_o",   {31'h0, irq}, 32'h0);
      check("rst prdata",  apb.prdata_o, 32'h0);
      check("rst pslverr", {31'h0, apb.pslverr_o}, 32'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post rst irq", {31'h0, irq}, 32'h0);
      check("post rst no start", start_cnt, 3);
      apb_read(12'h110, rd, err);
      check("post rst status", rd, 32'h1);
      apb_read(12'h11C, rd, err);
      check("post rst xfer_cnt", rd, 32'h0);
      apb_read(12'h114, rd, err);
      check("post rst irq_en", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
